// File: rtl/s6bitmulacc.sv
// Shift-and-add multiply-accumulate p = q*b + r, one multiplier bit per clock.
// Handshake: start is accepted only when the unit is free (idle or in its done cycle); busy covers accept..done, done pulses one cycle with p valid.
module s6bitmulacc #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_sum;
  logic               accept;
  logic               last_step;

  assign acc_sum   = mplier[0] ? acc + mcand : acc;
  assign last_step = (count == CW'(WIDTH - 1));
  // The edge that closes the done cycle may already accept the next request,
  // giving a WIDTH+1 cycle back-to-back period.
  assign accept    = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      p      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (accept) begin
      acc    <= {{WIDTH{1'b0}}, r};
      mcand  <= {{WIDTH{1'b0}}, b};
      mplier <= q;
      count  <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
      state  <= CALC;
    end else begin
      case (state)
        CALC: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (last_step) begin
            p     <= acc_sum;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
